// File: rtl/m72_pkg.sv
// m72_pkg -- shared types and constants for the M72 interrupt controller.
//   pic_state_t : initialisation sequencer states
//   OCW2_*      : OCW2 command codes carried in din[7:5]
package m72_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } pic_state_t;

    localparam logic [2:0] OCW2_NS_EOI = 3'b001;  // clear highest-priority in-service bit
    localparam logic [2:0] OCW2_SP_EOI = 3'b011;  // clear in-service bit din[2:0]

endpackage

// File: rtl/m72_pic_prio.sv
// m72_pic_prio -- 8-bit priority find-first, bit 0 is highest priority.
//   vec   in  8  candidate bits
//   valid out 1  any bit set
//   idx   out 3  index of the lowest-numbered set bit (0 when none set)
module m72_pic_prio (
    input  logic [7:0] vec,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |vec;
        idx   = 3'd0;
        // Walk from lowest priority upward so the highest-priority hit wins.
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/m72_pic.sv
// m72_pic -- 8259-style interrupt controller for the M72 V30 board.
//   CLK_32M, reset_n (async, active-low)
//   cs, wr, rd, a0, din[7:0], dout[7:0] : CPU register port
//   ir[7:0]        : interrupt request lines, IR0 highest priority
//   int_req        : interrupt request to the CPU
//   int_ack        : one-cycle acknowledge from the CPU
//   int_vector[8:0]: vector table byte address {type[6:0],2'b00}
// Optional build macro M72_PIC_LEVEL_EN: adds level-triggered mode (LTIM, ICW1 bit 3).
//
// state     | meaning
// UNINIT    | after reset, only ICW1 is accepted
// WAIT_ICW2 | expecting vector base on a0=1
// WAIT_ICW3 | cascade word, accepted and discarded
// WAIT_ICW4 | expecting mode word (AEOI)
// READY     | normal operation, requests enabled
module m72_pic
    import m72_pkg::*;
(
    input  logic       CLK_32M,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] ir,
    output logic       int_req,
    input  logic       int_ack,
    output logic [8:0] int_vector
);

    pic_state_t state;
    logic [7:0] irr, isr, imr, ir_prev;
    logic [7:0] irr_nxt, isr_nxt, irr_live, ir_edge;
    logic [3:0] base;
    logic       ic4, sngl, aeoi, ris;
    logic       wr_en, icw1, ocw2, ack_take, req_calc, rdy;
    logic       irr_vld, isr_vld;
    logic [2:0] irr_idx, isr_idx;
`ifdef M72_PIC_LEVEL_EN
    logic       ltim;
`endif

    // A cycle with both strobes is treated as a read, never a write.
    assign wr_en    = cs && wr && !rd;
    assign icw1     = wr_en && !a0 && din[4];
    assign ocw2     = wr_en && !a0 && (din[4:3] == 2'b00) && (state != UNINIT);
    assign rdy      = (state == READY);
    assign ir_edge  = ir & ~ir_prev;
    assign irr_live = irr & ~imr;
    assign ack_take = int_ack && int_req && irr_vld;

    m72_pic_prio u_prio_irr (.vec(irr_live), .valid(irr_vld), .idx(irr_idx));
    m72_pic_prio u_prio_isr (.vec(isr),      .valid(isr_vld), .idx(isr_idx));

    // A request wins only against strictly lower-priority (higher index) service.
    assign req_calc = rdy && irr_vld && (!isr_vld || (irr_idx < isr_idx));

    assign dout = a0 ? imr : (ris ? isr : irr);

    always_comb begin
        irr_nxt = irr;
        isr_nxt = isr;
        if (ack_take) begin
            irr_nxt[irr_idx] = 1'b0;
            if (!aeoi) isr_nxt[irr_idx] = 1'b1;
        end
        if (ocw2) begin
            if (din[7:5] == OCW2_NS_EOI && isr_vld) isr_nxt[isr_idx] = 1'b0;
            else if (din[7:5] == OCW2_SP_EOI)      isr_nxt[din[2:0]] = 1'b0;
        end
        // New edge applied after the ack clear so a coincident edge re-sets the bit.
`ifdef M72_PIC_LEVEL_EN
        if (ltim) begin
            if (rdy) irr_nxt = ir;
        end else if (rdy) begin
            irr_nxt = irr_nxt | ir_edge;
        end
`else
        if (rdy) irr_nxt = irr_nxt | ir_edge;
`endif
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state      <= UNINIT;
            irr        <= 8'h00;
            isr        <= 8'h00;
            imr        <= 8'hFF;
            base       <= 4'h0;
            aeoi       <= 1'b0;
            ris        <= 1'b0;
            ic4        <= 1'b0;
            sngl       <= 1'b1;
            ir_prev    <= 8'h00;
            int_req    <= 1'b0;
            int_vector <= 9'h000;
`ifdef M72_PIC_LEVEL_EN
            ltim       <= 1'b0;
`endif
        end else if (icw1) begin
            ic4     <= din[0];
            sngl    <= din[1];
            irr     <= 8'h00;
            isr     <= 8'h00;
            ir_prev <= 8'h00;
            imr     <= 8'hFF;
            aeoi    <= 1'b0;
            int_req <= 1'b0;
            state   <= WAIT_ICW2;
`ifdef M72_PIC_LEVEL_EN
            ltim    <= din[3];
`endif
        end else begin
            ir_prev <= ir;
            irr     <= irr_nxt;
            isr     <= isr_nxt;
            int_req <= ack_take ? 1'b0 : req_calc;
            if (ack_take) int_vector <= {base, irr_idx, 2'b00};

            if (wr_en && a0) begin
                case (state)
                    WAIT_ICW2: begin
                        base <= din[6:3];
                        if (!sngl)    state <= WAIT_ICW3;
                        else if (ic4) state <= WAIT_ICW4;
                        else          state <= READY;
                    end
                    WAIT_ICW3: state <= ic4 ? WAIT_ICW4 : READY;
                    WAIT_ICW4: begin
                        aeoi  <= din[1];
                        state <= READY;
                    end
                    READY:     imr <= din;
                    default:   ;
                endcase
            end

            if (wr_en && !a0 && (state != UNINIT) && (din[4:3] == 2'b01) && din[1])
                ris <= din[0];
        end
    end

endmodule
